// File: rtl/alu_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer_if
// Command/response bundle between a command source and alu_cmd_sequencer.
//   cmd_valid/cmd_ready   request handshake
//   cmd_op/cmd_a/cmd_b    opcode and operands
//   cmd_use_acc           take operand a from the accumulator (when built in)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_carry    captured result and masked carry
//   rsp_err               divide-by-zero flag
// Modports: master = command source, slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CTRL_W-1:0] cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Drives a combinational ALU: accepts one command at a time, holds registered
// operands/opcode on the ALU for SETTLE cycles, captures and sanitises the
// result, and returns it on a valid/ready response channel.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   bus (slave)         command/response channel, see alu_cmd_sequencer_if
//   alu_a/alu_b/alu_ctrl registered operands and opcode to the ALU
//   alu_out/alu_carry   ALU result and carry/borrow
//   busy                high whenever not idle
//   cmd_cnt             completed responses, wraps at 16 bits
//
// Parameters: DATA_W (8), CTRL_W (4), SETTLE (1, legal 1..15).
// Optional feature macro: ALU_ACC_FWD_EN adds an accumulator that captures
// every returned result and can replace operand a (cmd_use_acc).
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [CTRL_W-1:0]  alu_ctrl,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_carry,
  output logic               busy,
  output logic [15:0]        cmd_cnt
);

  localparam int CNT_W = 4;
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_DIV = CTRL_W'(3);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]  alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_err_q, rsp_err_d;
  logic [15:0]        cmd_cnt_q, cmd_cnt_d;
  logic               div_zero;
  logic               carry_valid;

`ifdef ALU_ACC_FWD_EN
  logic [DATA_W-1:0]  acc_q, acc_d;
`else
  logic               unused_use_acc;
  assign unused_use_acc = bus.cmd_use_acc;
`endif

  // The ALU only defines carry for add/sub; anything else is discarded.
  assign carry_valid = (alu_ctrl_q == OP_ADD) || (alu_ctrl_q == OP_SUB);
  assign div_zero    = (alu_ctrl_q == OP_DIV) && (alu_b_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    cmd_cnt_d   = cmd_cnt_q;
`ifdef ALU_ACC_FWD_EN
    acc_d       = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d    = bus.cmd_a;
`ifdef ALU_ACC_FWD_EN
          if (bus.cmd_use_acc) alu_a_d = acc_q;
`endif
          alu_b_d    = bus.cmd_b;
          alu_ctrl_d = bus.cmd_op;
          // Counter reaching zero marks the capture edge, so a load of
          // SETTLE-1 gives exactly SETTLE cycles from accept to response.
          cnt_d      = CNT_W'(SETTLE - 1);
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          rsp_data_d  = div_zero ? {DATA_W{1'b1}} : alu_out;
          rsp_carry_d = carry_valid ? alu_carry : 1'b0;
          rsp_err_d   = div_zero;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          cmd_cnt_d = cmd_cnt_q + 16'd1;
`ifdef ALU_ACC_FWD_EN
          acc_d     = rsp_data_q;
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cmd_cnt_q   <= '0;
`ifdef ALU_ACC_FWD_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      cmd_cnt_q   <= cmd_cnt_d;
`ifdef ALU_ACC_FWD_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // Ready is withheld while reset is asserted so nothing is offered then.
  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_err   = rsp_err_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign busy          = (state_q != IDLE);
  assign cmd_cnt       = cmd_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n;
  bit   sel;  // 0: SETTLE=1 instance, 1: SETTLE=3 instance

  logic       cmd_valid, cmd_use_acc, rsp_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;

  alu_cmd_sequencer_if #(.DATA_W(8), .CTRL_W(4)) if1 ();
  alu_cmd_sequencer_if #(.DATA_W(8), .CTRL_W(4)) if3 ();

  logic [7:0] alu1_a, alu1_b, alu1_out, alu3_a, alu3_b, alu3_out;
  logic [3:0] alu1_ctrl, alu3_ctrl;
  logic       alu1_carry, alu3_carry, busy1, busy3;
  logic [15:0] cnt1, cnt3;

  assign if1.cmd_valid   = cmd_valid & ~sel;
  assign if3.cmd_valid   = cmd_valid & sel;
  assign if1.rsp_ready   = rsp_ready & ~sel;
  assign if3.rsp_ready   = rsp_ready & sel;
  assign if1.cmd_op      = cmd_op;
  assign if3.cmd_op      = cmd_op;
  assign if1.cmd_a       = cmd_a;
  assign if3.cmd_a       = cmd_a;
  assign if1.cmd_b       = cmd_b;
  assign if3.cmd_b       = cmd_b;
  assign if1.cmd_use_acc = cmd_use_acc;
  assign if3.cmd_use_acc = cmd_use_acc;

  // Reference ALU: carry is meaningful for add/sub only; other ops drive 1
  // so that an unmasked carry would be visible.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return {1'b0, a} + {1'b0, b};
      4'h1:    return {a < b, 8'(a - b)};
      4'h2:    return {1'b1, 8'(a * b)};
      4'h3:    return {1'b1, (b == 8'h00) ? 8'h00 : 8'(a / b)};
      4'h4:    return {1'b1, 8'(a << 1)};
      default: return {1'b1, a & b};
    endcase
  endfunction

  assign {alu1_carry, alu1_out} = alu_f(alu1_ctrl, alu1_a, alu1_b);
  assign {alu3_carry, alu3_out} = alu_f(alu3_ctrl, alu3_a, alu3_b);

  alu_cmd_sequencer #(.DATA_W(8), .CTRL_W(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(if1.slave),
    .alu_a(alu1_a), .alu_b(alu1_b), .alu_ctrl(alu1_ctrl),
    .alu_out(alu1_out), .alu_carry(alu1_carry),
    .busy(busy1), .cmd_cnt(cnt1)
  );

  alu_cmd_sequencer #(.DATA_W(8), .CTRL_W(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .bus(if3.slave),
    .alu_a(alu3_a), .alu_b(alu3_b), .alu_ctrl(alu3_ctrl),
    .alu_out(alu3_out), .alu_carry(alu3_carry),
    .busy(busy3), .cmd_cnt(cnt3)
  );

  // Observation taps following the selected instance.
  wire        o_cmd_ready = sel ? if3.cmd_ready : if1.cmd_ready;
  wire        o_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  wire [7:0]  o_rsp_data  = sel ? if3.rsp_data  : if1.rsp_data;
  wire        o_rsp_carry = sel ? if3.rsp_carry : if1.rsp_carry;
  wire        o_rsp_err   = sel ? if3.rsp_err   : if1.rsp_err;
  wire [7:0]  o_alu_a     = sel ? alu3_a : alu1_a;
  wire [7:0]  o_alu_b     = sel ? alu3_b : alu1_b;
  wire [3:0]  o_alu_ctrl  = sel ? alu3_ctrl : alu1_ctrl;
  wire        o_busy      = sel ? busy3 : busy1;
  wire [15:0] o_cnt       = sel ? cnt3 : cnt1;

`ifdef ALU_ACC_FWD_EN
  localparam logic [7:0] ACC_A   = 8'h07;
  localparam logic [7:0] ACC_EXP = 8'h08;
`else
  localparam logic [7:0] ACC_A   = 8'h55;
  localparam logic [7:0] ACC_EXP = 8'h56;
`endif

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input bit s, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic ua, input logic [7:0] ea, input logic [7:0] ed,
                     input logic ec, input logic ee, input int hold, input logic [15:0] ecnt);
    int lat;
    sel = s;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", o_cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_use_acc = 1'b0;
    chk("alu_a", o_alu_a, ea);
    chk("alu_b", o_alu_b, b);
    chk("alu_ctrl", o_alu_ctrl, op);
    chk("busy_exec", o_busy, 1);
    chk("cmd_ready_exec", o_cmd_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!o_rsp_valid && lat < 40);
    chk("latency", lat, s ? 3 : 1);
    chk("rsp_data", o_rsp_data, ed);
    chk("rsp_carry", o_rsp_carry, ec);
    chk("rsp_err", o_rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_rsp_valid, 1);
      chk("hold_data", o_rsp_data, ed);
      chk("hold_alu_a", o_alu_a, ea);
      chk("hold_cmd_ready", o_cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", o_rsp_valid, 0);
    chk("busy_idle", o_busy, 0);
    chk("cmd_cnt", o_cnt, ecnt);
    chk("alu_b_kept", o_alu_b, b);
    $display("txn dut%0d op=%h a=%h b=%h acc=%b -> data=%h carry=%b err=%b lat=%0d cnt=%0d",
             s ? 3 : 1, op, a, b, ua, o_rsp_data, o_rsp_carry, o_rsp_err, lat, o_cnt);
  endtask

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0; sel = 1'b0;
    cmd_valid = 1'b0; cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", if1.cmd_ready, 0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_cmd_ready", o_cmd_ready, 1);
    chk("post_reset_busy", o_busy, 0);
    chk("post_reset_cnt", o_cnt, 0);
    chk("post_reset_rsp_valid", o_rsp_valid, 0);
    chk("post_reset_alu_a", o_alu_a, 0);
    chk("post_reset_rsp_data", o_rsp_data, 0);

    // SETTLE=1 instance
    run(0, 4'h0, 8'hF0, 8'h20, 0, 8'hF0, 8'h10, 1, 0, 0, 16'd1);
    run(0, 4'h1, 8'h05, 8'h07, 0, 8'h05, 8'hFE, 1, 0, 0, 16'd2);
    run(0, 4'h4, 8'h81, 8'h00, 0, 8'h81, 8'h02, 0, 0, 0, 16'd3);
    run(0, 4'h3, 8'h40, 8'h00, 0, 8'h40, 8'hFF, 0, 1, 0, 16'd4);
    run(0, 4'h3, 8'h40, 8'h04, 0, 8'h40, 8'h10, 0, 0, 0, 16'd5);
    run(0, 4'h2, 8'h12, 8'h10, 0, 8'h12, 8'h20, 0, 0, 0, 16'd6);
    run(0, 4'h0, 8'h03, 8'h04, 0, 8'h03, 8'h07, 0, 0, 0, 16'd7);
    run(0, 4'h0, 8'h55, 8'h01, 1, ACC_A, ACC_EXP, 0, 0, 0, 16'd8);

    // SETTLE=3 instance with 5 cycles of response backpressure
    run(1, 4'h0, 8'h12, 8'h34, 0, 8'h12, 8'h46, 0, 0, 5, 16'd1);

    // Reset in the middle of the settle window
    sel = 1'b1;
    cmd_op = 4'h0; cmd_a = 8'h10; cmd_b = 8'h20; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    chk("midrst_alu_a", o_alu_a, 0);
    chk("midrst_alu_b", o_alu_b, 0);
    chk("midrst_rsp_valid", o_rsp_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_cnt", o_cnt, 0);
    chk("midrst_cmd_ready", o_cmd_ready, 0);
    @(posedge clk); #1;
    rst3_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_rsp", o_rsp_valid, 0);
    chk("midrst_ready", o_cmd_ready, 1);
    run(1, 4'h0, 8'h01, 8'h01, 0, 8'h01, 8'h02, 0, 0, 0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator/driver side of the 8-bit combinational ALU interface (a, b, 4-bit ctrl in; out, carry back).
- Accepts one command at a time on a valid/ready request channel and drives registered operands and opcode to the ALU.
- Waits a programmable settle time, then captures and sanitises the result.
- Returns the result on a valid/ready response channel; counts completed operations.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- CTRL_W, 4, opcode width.
- SETTLE, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request ready.
- cmd_op  in  CTRL_W  ALU opcode.
- cmd_a  in  DATA_W  operand a.
- cmd_b  in  DATA_W  operand b.
- cmd_use_acc  in  1  substitute the accumulator for operand a (feature only).
- alu_a  out  DATA_W  registered operand a to the ALU.
- alu_b  out  DATA_W  registered operand b to the ALU.
- alu_ctrl  out  CTRL_W  registered opcode to the ALU.
- alu_out  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry/borrow.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_data  out  DATA_W  captured result.
- rsp_carry  out  1  masked carry.
- rsp_err  out  1  divide-by-zero flag.
- busy  out  1  high in any state other than IDLE.
- cmd_cnt  out  16  count of completed responses; wraps.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; alu_a, alu_b, alu_ctrl, rsp_data, rsp_carry, rsp_err, rsp_valid, busy, cmd_cnt, settle counter all 0. cmd_ready is 1 once rst_n is released.
- Reset mid-operation: any in-flight command is dropped; no response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge t0: register cmd_a/cmd_b/cmd_op onto alu_a/alu_b/alu_ctrl, load settle counter with SETTLE-1, go to EXEC.
- EXEC:
  - cmd_ready=0; alu_* held stable.
  - Counter decrements each cycle. At the edge where the counter is 0, capture the result and go to RESP.
  - rsp_valid rises exactly SETTLE cycles after t0.
- Capture rules:
  - rsp_data = alu_out.
  - rsp_carry = alu_carry only for opcodes 0000 (add) and 0001 (sub), else 0. The ALU leaves carry unassigned for the other ops, so it is never trusted there.
  - rsp_err = 1 iff opcode 0011 (divide) and alu_b==0; in that case rsp_data is forced to 0xFF.
  - Multiply (0010) returns the low DATA_W bits only; no overflow flag.
- RESP:
  - rsp_valid=1. rsp_data/carry/err stay stable until rsp_valid&rsp_ready.
  - On the handshake edge: rsp_valid→0, cmd_cnt+1 (0xFFFF→0x0000), go to IDLE.
- Throughput:
  - No bypass: cmd_ready is 0 during EXEC and RESP, even if rsp_ready is high.
  - Minimum command spacing is SETTLE+2 cycles.
- alu_* keep their last values in IDLE; they change only on command acceptance.
- cmd_valid while cmd_ready=0 is ignored; the source must hold it.
- Opcodes are passed to the ALU unchanged; no opcode is illegal.

Optional Feature:
- Macro ALU_ACC_FWD_EN.
- Defined:
  - Adds a DATA_W accumulator, reset 0.
  - The accumulator loads rsp_data on every response handshake, including error responses (0xFF).
  - On acceptance with cmd_use_acc=1, alu_a is loaded from the accumulator instead of cmd_a.
- Undefined:
  - No accumulator register.
  - cmd_use_acc is ignored; alu_a always comes from cmd_a.

Test Plan:
- Add, SETTLE=1: op 0000, a=0xF0, b=0x20 → rsp_data=0x10, rsp_carry=1, rsp_err=0; rsp_valid high exactly 1 cycle after accept; cmd_cnt=1.
- Subtract with borrow: op 0001, a=0x05, b=0x07 → rsp_data=0xFE, rsp_carry=1. Then op 0100, a=0x81 → rsp_data=0x02, rsp_carry=0 (masked).
- Divide by zero: op 0011, a=0x40, b=0x00 → rsp_data=0xFF, rsp_err=1. Then op 0011, a=0x40, b=0x04 → rsp_data=0x10, rsp_err=0.
- Backpressure, SETTLE=3: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_data and alu_* stable, cmd_ready=0. Release → IDLE next cycle, cmd_cnt increments once; total spacing ≥5 cycles.
- Reset during EXEC: drop rst_n mid-settle → all outputs 0 immediately, no response, cmd_cnt=0. Next add 0x01+0x01 → 0x02.
- Accumulator chaining: op 0000 3+4 → 0x07. Then cmd_use_acc=1, op 0000, cmd_a=0x55, b=0x01 → 0x08 with ALU_ACC_FWD_EN defined, 0x56 without.
